decode_stage: RTL and testbench

- RV32I integer decode stage. It is the producer side of the dec2exPkt interface consumed by the execute stage.
- Registers the fetched instruction (if2decPkt) and reads two operands from an internal register file.
- Forwards results from the execute and writeback stages, then emits a fully resolved dec2exPkt: pc, inst32, instValid, aluOp, src1, src2, destReg.
- Also owns the architectural register-file write port driven by writeback.

---
 rtl/akarin_pkg.sv | 82 ++++++++
 rtl/decode_stage_reg_file.sv | 44 ++++
 rtl/decode_stage.sv | 157 +++++++++++++++
 tb/tb_decode_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/akarin_pkg.sv
// Shared RV32I front-end types: fetch/decode/execute packets, ALU opcodes and
// the instruction-field constants used to decode them.
package akarin_pkg;

    localparam int PKT_XLEN = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef struct packed {
        logic [PKT_XLEN-1:0] pc;
        logic [31:0]         inst32;
        logic                instValid;
    } if2decPkt;

    typedef struct packed {
        logic                instValid;
        logic [4:0]          destReg;
        logic [PKT_XLEN-1:0] res;
    } ex2wbPkt;

    typedef struct packed {
        logic [PKT_XLEN-1:0] pc;
        logic [31:0]         inst32;
        logic                instValid;
        alu_op_t             aluOp;
        logic [PKT_XLEN-1:0] src1;
        logic [PKT_XLEN-1:0] src2;
        logic [4:0]          destReg;
    } dec2exPkt;

    // alt selects the funct7[5] variant, which only exists for ADD/SUB and SRL/SRA.
    function automatic alu_op_t alu_base_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

    function automatic logic [PKT_XLEN-1:0] imm_i(input logic [31:0] inst);
        return {{(PKT_XLEN-12){inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [PKT_XLEN-1:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two asynchronous read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module reg_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [IDX_W-1:0] rs1_addr,
    output logic [XLEN-1:0]  rs1_data,
    input  logic [IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]  rs2_data
);

    logic [XLEN-1:0]             regs_reg [NUM_REGS];
    logic [1:0][IDX_W-1:0]       rd_addr;
    logic [1:0][XLEN-1:0]        rd_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && wr_addr != '0) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_addr  = {rs2_addr, rs1_addr};
    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];

    // A read of the register being written this cycle sees the new value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                             (we && wr_addr == rd_addr[gi]) ? wr_data :
                             regs_reg[rd_addr[gi]];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I integer decode: registers the fetched instruction, reads and forwards
// operands, and emits a resolved dec2exPkt for the execute stage.
module decode_stage
    import akarin_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  if2decPkt             if2dec_i,
    input  ex2wbPkt              ex2wb_i,
    input  logic                 wb_we,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output dec2exPkt             dec2ex_o,
    output logic                 illegal_o,
    output logic [ILL_CNT_W-1:0] illegal_cnt_o
);

    if2decPkt             inst_reg;
    logic                 fresh_reg;
    logic [ILL_CNT_W-1:0] illegal_cnt_reg;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            is_shift;
    logic            legal;
    alu_op_t         alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            valid_dec;

    // fresh_reg marks the first cycle an instruction occupies the register, so
    // an illegal word held by stall is counted only once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_reg        <= '0;
            fresh_reg       <= 1'b0;
            illegal_cnt_reg <= '0;
        end else begin
            if (flush) begin
                inst_reg  <= '0;
                fresh_reg <= 1'b0;
            end else if (!stall) begin
                inst_reg  <= if2dec_i;
                fresh_reg <= 1'b1;
            end else begin
                fresh_reg <= 1'b0;
            end
            if (fresh_reg && illegal_o && illegal_cnt_reg != '1) begin
                illegal_cnt_reg <= illegal_cnt_reg + ILL_CNT_W'(1);
            end
        end
    end

    assign opcode = inst_reg.inst32[6:0];
    assign rd     = inst_reg.inst32[11:7];
    assign funct3 = inst_reg.inst32[14:12];
    assign rs1    = inst_reg.inst32[19:15];
    assign rs2    = inst_reg.inst32[24:20];
    assign funct7 = inst_reg.inst32[31:25];

    reg_file #(
        .XLEN    (XLEN),
        .NUM_REGS(NUM_REGS),
        .IDX_W   (5)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .wr_addr (wb_rd),
        .wr_data (wb_data),
        .rs1_addr(rs1),
        .rs1_data(rs1_rf),
        .rs2_addr(rs2),
        .rs2_data(rs2_rf)
    );

    // The execute-stage result is younger than anything in the register file.
    assign rs1_val = (rs1 == '0) ? '0 :
                     (ex2wb_i.instValid && ex2wb_i.destReg == rs1) ? ex2wb_i.res : rs1_rf;
    assign rs2_val = (rs2 == '0) ? '0 :
                     (ex2wb_i.instValid && ex2wb_i.destReg == rs2) ? ex2wb_i.res : rs2_rf;

    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_NOP;
        src1   = '0;
        src2   = '0;
        case (opcode)
            OPC_OP: begin
                legal  = (funct7 == F7_BASE) ||
                         (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
                alu_op = alu_base_op(funct3, funct7 == F7_ALT);
                src1   = rs1_val;
                src2   = is_shift ? XLEN'(rs2_val[4:0]) : rs2_val;
            end
            OPC_OPIMM: begin
                src1 = rs1_val;
                if (is_shift) begin
                    legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT && funct3 == F3_SRL_SRA);
                    alu_op = alu_base_op(funct3, funct7 == F7_ALT);
                    src2   = XLEN'(rs2);
                end else begin
                    // funct7 bits are immediate here, and there is no SUBI.
                    legal  = 1'b1;
                    alu_op = alu_base_op(funct3, 1'b0);
                    src2   = imm_i(inst_reg.inst32);
                end
            end
            OPC_LUI: begin
                legal  = 1'b1;
                alu_op = ALU_ADD;
                src2   = imm_u(inst_reg.inst32);
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                alu_op = ALU_ADD;
                src1   = inst_reg.pc;
                src2   = imm_u(inst_reg.inst32);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign valid_dec     = inst_reg.instValid && legal;
    assign illegal_o     = inst_reg.instValid && !legal;
    assign illegal_cnt_o = illegal_cnt_reg;

    always_comb begin
        dec2ex_o           = '0;
        dec2ex_o.pc        = inst_reg.pc;
        dec2ex_o.inst32    = inst_reg.inst32;
        dec2ex_o.instValid = valid_dec;
        dec2ex_o.aluOp     = valid_dec ? alu_op : ALU_NOP;
        dec2ex_o.src1      = valid_dec ? src1 : '0;
        dec2ex_o.src2      = valid_dec ? src2 : '0;
        dec2ex_o.destReg   = valid_dec ? rd : 5'd0;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage against an instruction-level
// reference model of the decode rules, register file and illegal counter.
module tb_decode_stage;
    import akarin_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             stall;
    logic             flush;
    if2decPkt         if2dec;
    ex2wbPkt          ex2wb;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    dec2exPkt         dec2ex;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    decode_stage #(
        .XLEN     (32),
        .NUM_REGS (32),
        .ILL_CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if2dec_i     (if2dec),
        .ex2wb_i      (ex2wb),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .dec2ex_o     (dec2ex),
        .illegal_o    (illegal),
        .illegal_cnt_o(illegal_cnt)
    );

    int checks = 0;
    int errors = 0;

    if2decPkt    m_pipe;
    logic [31:0] m_regs [32];
    int          m_cnt;
    bit          m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural operand value as the decode stage should see it right now.
    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (ex2wb.instValid && ex2wb.destReg == r) return ex2wb.res;
        if (wb_we && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic void ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                       output bit ok, output alu_op_t op,
                                       output logic [31:0] a, output logic [31:0] b);
        alu_op_t    tab [8];
        logic [6:0] f7;
        int         f3;
        bit         shift;
        tab   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f7    = inst[31:25];
        f3    = int'(inst[14:12]);
        shift = (f3 == 1) || (f3 == 5);
        ok = 1'b0; op = ALU_NOP; a = 32'd0; b = 32'd0;
        case (inst[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                op = tab[f3];
                if (f7 == 7'h20 && f3 == 0) op = ALU_SUB;
                if (f7 == 7'h20 && f3 == 5) op = ALU_SRA;
                a = operand(inst[19:15]);
                b = operand(inst[24:20]);
                if (shift) b = b % 32;
            end
            7'h13: begin
                a = operand(inst[19:15]);
                if (shift) begin
                    ok = (f7 == 7'h00) || (f3 == 5 && f7 == 7'h20);
                    op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
                    b  = 32'(inst[24:20]);
                end else begin
                    ok = 1'b1;
                    op = tab[f3];
                    b  = int'($signed(inst[31:20]));
                end
            end
            7'h37: begin ok = 1'b1; op = ALU_ADD; b = inst & 32'hFFFF_F000; end
            7'h17: begin ok = 1'b1; op = ALU_ADD; a = pc; b = inst & 32'hFFFF_F000; end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_clock();
        bit ok; alu_op_t op; logic [31:0] a, b;
        if (!rst) begin
            m_pipe = '0; m_cnt = 0; m_pend = 1'b0;
            foreach (m_regs[i]) m_regs[i] = 32'd0;
        end else begin
            if (m_pend && m_cnt != CNT_MAX) m_cnt++;
            if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
            if (flush) begin
                m_pipe = '0; m_pend = 1'b0;
            end else if (!stall) begin
                ref_decode(if2dec.inst32, if2dec.pc, ok, op, a, b);
                m_pipe = if2dec;
                m_pend = if2dec.instValid && !ok;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        bit ok; alu_op_t op; logic [31:0] a, b; logic [4:0] rd; bit vld;
        ref_decode(m_pipe.inst32, m_pipe.pc, ok, op, a, b);
        vld = m_pipe.instValid && ok;
        rd  = vld ? m_pipe.inst32[11:7] : 5'd0;
        if (!vld) begin op = ALU_NOP; a = 32'd0; b = 32'd0; end
        check({tag, ".pc"},    dec2ex.pc, m_pipe.pc);
        check({tag, ".inst"},  dec2ex.inst32, m_pipe.inst32);
        check({tag, ".valid"}, 32'(dec2ex.instValid), 32'(vld));
        check({tag, ".op"},    32'(dec2ex.aluOp), 32'(op));
        check({tag, ".src1"},  dec2ex.src1, a);
        check({tag, ".src2"},  dec2ex.src2, b);
        check({tag, ".rd"},    32'(dec2ex.destReg), 32'(rd));
        check({tag, ".ill"},   32'(illegal), 32'(m_pipe.instValid && !ok));
        check({tag, ".cnt"},   32'(illegal_cnt), 32'(m_cnt));
        $display("%-16s t=%0t inst=%h v=%0b op=%0d s1=%h s2=%h rd=%0d ill=%0b cnt=%0d",
                 tag, $time, dec2ex.inst32, dec2ex.instValid, dec2ex.aluOp,
                 dec2ex.src1, dec2ex.src2, dec2ex.destReg, illegal, illegal_cnt);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance(input string tag);
        compare_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic tick(input string tag);
        settle();
        advance(tag);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input bit vld);
        if2dec.pc        = pc;
        if2dec.inst32    = inst;
        if2dec.instValid = vld;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        int         k;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        f7  = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
        k   = int'($urandom_range(0, 9));
        case (k)
            0, 1, 2: return {f7, rs2, rs1, f3, rd, 7'h33};
            3:       return {7'($urandom), rs2, rs1, f3, rd, 7'h33};
            4, 5:    return {12'($urandom), rs1, f3, rd, 7'h13};
            6:       return {f7, 5'($urandom), rs1, ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001, rd, 7'h13};
            7:       return {20'($urandom), rd, 7'h37};
            8:       return {20'($urandom), rd, 7'h17};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        ex2wb = '0; if2dec = '0;
        m_pipe = '0; m_cnt = 0; m_pend = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        @(posedge clk);
        model_clock();
        #1;

        settle();
        check("reset_valid", 32'(dec2ex.instValid), 32'd0);
        check("reset_cnt", 32'(illegal_cnt), 32'd0);
        advance("reset");
        rst = 1'b1;

        drive(32'h100, 32'h0050_0093, 1'b1);            // addi x1,x0,5
        tick("load_addi");
        drive(32'h104, 32'h0010_8133, 1'b1);            // add x2,x1,x1
        settle();
        check("addi_op", 32'(dec2ex.aluOp), 32'(ALU_ADD));
        check("addi_src1", dec2ex.src1, 32'd0);
        check("addi_src2", dec2ex.src2, 32'd5);
        check("addi_rd", 32'(dec2ex.destReg), 32'd1);
        check("addi_valid", 32'(dec2ex.instValid), 32'd1);
        advance("addi");

        ex2wb.instValid = 1'b1; ex2wb.destReg = 5'd1; ex2wb.res = 32'd5;
        drive(32'h108, 32'h4001_8233, 1'b1);            // sub x4,x3,x0
        settle();
        check("add_fwd_src1", dec2ex.src1, 32'd5);
        check("add_fwd_src2", dec2ex.src2, 32'd5);
        advance("add_fwd");

        ex2wb.instValid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        drive(32'h10C, 32'h1234_52B7, 1'b1);            // lui x5,0x12345
        settle();
        check("sub_bypass_src1", dec2ex.src1, 32'hDEAD_BEEF);
        check("sub_op", 32'(dec2ex.aluOp), 32'(ALU_SUB));
        advance("sub_bypass");

        wb_we = 1'b0;
        drive(32'h110, 32'h4042_D313, 1'b1);            // srai x6,x5,4
        settle();
        check("lui_src1", dec2ex.src1, 32'd0);
        check("lui_src2", dec2ex.src2, 32'h1234_5000);
        check("lui_op", 32'(dec2ex.aluOp), 32'(ALU_ADD));
        advance("lui");

        drive(32'h114, 32'h4001_8433, 1'b1);            // sub x8,x3,x0
        settle();
        check("srai_op", 32'(dec2ex.aluOp), 32'(ALU_SRA));
        check("srai_src2", dec2ex.src2, 32'd4);
        advance("srai");

        drive(32'h118, 32'hFFFF_FFFF, 1'b1);
        settle();
        check("x3_held", dec2ex.src1, 32'hDEAD_BEEF);
        advance("x3_readback");

        stall = 1'b1;
        drive(32'h11C, 32'h0050_0093, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ill_flag", 32'(illegal), 32'd1);
            check("ill_op", 32'(dec2ex.aluOp), 32'(ALU_NOP));
            check("ill_cnt", 32'(illegal_cnt), (i == 0) ? 32'd0 : 32'd1);
            advance("illegal_stall");
        end
        stall = 1'b0;
        settle();
        check("ill_release_flag", 32'(illegal), 32'd1);
        check("ill_release_cnt", 32'(illegal_cnt), 32'd1);
        advance("illegal_release");

        stall = 1'b1; flush = 1'b1;
        drive(32'h120, 32'h0050_0093, 1'b1);
        tick("stall_flush");
        stall = 1'b0; flush = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd1;
        drive(32'h124, 32'h0000_03B3, 1'b1);            // add x7,x0,x0
        settle();
        check("flush_bubble_valid", 32'(dec2ex.instValid), 32'd0);
        check("flush_bubble_ill", 32'(illegal), 32'd0);
        check("cnt_after_flush", 32'(illegal_cnt), 32'd1);
        advance("x0_write");

        wb_we = 1'b0;
        drive(32'h128, 32'h0010_8133, 1'b1);
        settle();
        check("x0_src1", dec2ex.src1, 32'd0);
        check("x0_src2", dec2ex.src2, 32'd0);
        check("x0_rd", 32'(dec2ex.destReg), 32'd7);
        advance("add_x0");

        rst = 1'b0;
        tick("mid_reset");
        rst = 1'b1;
        drive(32'h12C, 32'h4001_8433, 1'b1);            // sub x8,x3,x0
        settle();
        check("post_reset_valid", 32'(dec2ex.instValid), 32'd0);
        check("post_reset_cnt", 32'(illegal_cnt), 32'd0);
        advance("post_reset");
        drive(32'h130, 32'h0000_0000, 1'b0);
        settle();
        check("x3_cleared", dec2ex.src1, 32'd0);
        advance("x3_cleared");

        for (int i = 0; i < 18; i++) begin
            drive(32'h200 + 32'(i * 4), 32'hFFFF_FFFF, 1'b1);
            tick("ill_burst");
        end
        drive(32'h0, 32'h0, 1'b0);
        tick("burst_drain");
        settle();
        check("cnt_saturated", 32'(illegal_cnt), 32'(CNT_MAX));
        advance("saturate");

        for (int i = 0; i < 300; i++) begin
            rst             = ($urandom_range(0, 99) != 0);
            stall           = ($urandom_range(0, 5) == 0);
            flush           = ($urandom_range(0, 11) == 0);
            ex2wb.instValid = ($urandom_range(0, 1) == 1);
            ex2wb.destReg   = 5'($urandom_range(0, 7));
            ex2wb.res       = $urandom;
            wb_we           = ($urandom_range(0, 1) == 1);
            wb_rd           = 5'($urandom_range(0, 7));
            wb_data         = $urandom;
            drive($urandom & 32'hFFFF_FFFC, gen_inst(), ($urandom_range(0, 7) != 0));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
